// File: rtl/tx_pkg.sv
// Shared types and ASCII helpers for the hex-dump transmit scheduler.
package tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;

    function automatic logic [7:0] nib2ascii(input logic [3:0] n);
        logic [7:0] n8;
        n8 = {4'h0, n};
        if (n <= 4'd9) begin
            return ASCII_0 + n8;
        end
        return ASCII_A + n8 - 8'd10;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from last+1.
module rr_arbiter #(
    parameter int NCH = 2
) (
    input  logic [NCH-1:0]         req,
    input  logic [$clog2(NCH)-1:0] last,
    input  logic                   enable,
    output logic [NCH-1:0]         grant,
    output logic [$clog2(NCH)-1:0] grant_idx,
    output logic                   valid
);
    localparam int IW = $clog2(NCH);

    always_comb begin
        int unsigned c;
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        c         = 0;
        if (enable) begin
            for (int unsigned k = 1; k <= NCH; k++) begin
                c = (32'(last) + k) % NCH;
                if (!valid && req[c]) begin
                    valid     = 1'b1;
                    grant[c]  = 1'b1;
                    grant_idx = IW'(c);
                end
            end
        end
    end

endmodule

// File: rtl/tx_hex_sched.sv
// Shares one UART byte transmitter among NCH requesters, sending each word as
// uppercase ASCII hex (MSB nibble first), optionally terminated by CR LF.
module tx_hex_sched
    import tx_pkg::*;
#(
    parameter int NCH    = 2,
    parameter int DIGITS = 8,
    parameter int EOL    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH-1:0]           req,
    input  logic [NCH*4*DIGITS-1:0]  word,
    output logic [NCH-1:0]           ack,
    output logic                     busy,
    output logic [$clog2(NCH)-1:0]   grant_id,
    output logic                     tx_ready,
    output logic [7:0]               tx_data,
    input  logic                     tx_rd
);
    localparam int W  = 4 * DIGITS;
    localparam int N  = DIGITS + 2 * EOL;
    localparam int IW = $clog2(NCH);
    localparam int XW = (N > 1) ? $clog2(N) : 1;

    state_t          state_q, state_d;
    logic [W-1:0]    word_q, word_d;
    logic [XW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   grant_id_q, grant_id_d;
    logic [NCH-1:0]  ack_q, ack_d;
    logic            busy_q, busy_d;
    logic            tx_ready_q, tx_ready_d;
    logic [7:0]      tx_data_q, tx_data_d;

    logic [NCH-1:0]  arb_grant;
    logic [IW-1:0]   arb_idx;
    logic            arb_valid;
    logic [W-1:0]    sel_word;

    function automatic logic [7:0] char_of(input logic [W-1:0] w, input logic [XW-1:0] i);
        logic [W-1:0] sh;
        if (32'(i) < DIGITS) begin
            sh = w >> (4 * (DIGITS - 1 - int'(i)));
            return nib2ascii(sh[3:0]);
        end else if (32'(i) == DIGITS) begin
            return ASCII_CR;
        end
        return ASCII_LF;
    endfunction

    rr_arbiter #(.NCH(NCH)) u_arb (
        .req       (req),
        .last      (last_q),
        .enable    (state_q == ST_IDLE),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .valid     (arb_valid)
    );

    always_comb begin
        sel_word = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (arb_grant[i]) sel_word = word[i*W +: W];
        end
    end

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        idx_d      = idx_q;
        last_d     = last_q;
        grant_id_d = grant_id_q;
        ack_d      = '0;
        busy_d     = busy_q;
        tx_ready_d = tx_ready_q;
        tx_data_d  = tx_data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    word_d     = sel_word;
                    grant_id_d = arb_idx;
                    last_d     = arb_idx;
                    idx_d      = '0;
                    ack_d      = arb_grant;
                    busy_d     = 1'b1;
                    tx_ready_d = 1'b1;
                    tx_data_d  = char_of(sel_word, '0);
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_rd) begin
                    tx_ready_d = 1'b0;
                    if (idx_q == XW'(N - 1)) begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + XW'(1);
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                tx_ready_d = 1'b1;
                tx_data_d  = char_of(word_q, idx_q);
                state_d    = ST_SEND;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            word_q     <= '0;
            idx_q      <= '0;
            last_q     <= IW'(NCH - 1);
            grant_id_q <= '0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
            tx_ready_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            grant_id_q <= grant_id_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            tx_ready_q <= tx_ready_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign ack      = ack_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;
    assign tx_ready = tx_ready_q;
    assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_tx_hex_sched.sv
// Bench for tx_hex_sched: vector table, hand sequences, randomized traffic vs. a string-level model.
module tb_tx_hex_sched;

    localparam int NCH = 3;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [95:0] word;
    logic [2:0]  ack;
    logic        busy;
    logic [1:0]  grant_id;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_rd;

    logic [1:0]  req_b;
    logic [15:0] word_b;
    logic [1:0]  ack_b;
    logic        busy_b;
    logic [0:0]  gid_b;
    logic        txr_b;
    logic [7:0]  txd_b;
    logic        tx_rd_b;

    int checks   = 0;
    int failures = 0;
    int last_m   = NCH - 1;

    tx_hex_sched #(.NCH(3), .DIGITS(8), .EOL(1)) dut (
        .clk(clk), .rst(rst), .req(req), .word(word), .ack(ack), .busy(busy),
        .grant_id(grant_id), .tx_ready(tx_ready), .tx_data(tx_data), .tx_rd(tx_rd)
    );

    tx_hex_sched #(.NCH(2), .DIGITS(2), .EOL(0)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .word(word_b), .ack(ack_b), .busy(busy_b),
        .grant_id(gid_b), .tx_ready(txr_b), .tx_data(txd_b), .tx_rd(tx_rd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: bench exceeded time limit (checks=%0d)", checks);
        $fatal(1);
    end

    typedef struct {
        logic [2:0]  req;
        logic [95:0] words;
        int          ch;
        string       exp;
        int          dly;
        bit          keep;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input logic [2:0] r, input logic [95:0] w, input int ch,
                           input string exp, input int dly, input bit keep);
        vec_t v;
        v.req = r; v.words = w; v.ch = ch; v.exp = exp; v.dly = dly; v.keep = keep;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the hex text of a word, built from string operations.
    function automatic string model_str(input logic [31:0] w);
        string hx = "0123456789ABCDEF";
        string s  = "";
        for (int i = 7; i >= 0; i--) begin
            int n = int'((w >> (4 * i)) & 32'hF);
            s = $sformatf("%s%s", s, hx.substr(n, n));
        end
        return {s, "\r\n"};
    endfunction

    function automatic int pick(input logic [2:0] r, input int last);
        for (int k = 1; k <= NCH; k++) begin
            int c = (last + k) % NCH;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    // Starts at the negedge before the grant edge; ends at a negedge after the n_rd-th tx_rd.
    task automatic run_word(input int ch, input string exp, input int rd_delay,
                            input bit keep, input int n_rd);
        int n = exp.len();
        logic [2:0] one = 3'b001 << ch;
        @(negedge clk);
        chk("ack", ack, one);
        chk("grant_id", grant_id, ch);
        chk("busy_on_grant", busy, 1);
        chk("ready_on_grant", tx_ready, 1);
        chk("byte0", tx_data, exp[0]);
        last_m = ch;
        if (!keep) begin
            req[ch] = 1'b0;
            word[ch*32 +: 32] = $urandom;
        end
        for (int b = 0; b < n_rd; b++) begin
            for (int d = 0; d < rd_delay; d++) begin
                @(negedge clk);
                chk("stall_ready", tx_ready, 1);
                chk("stall_data", tx_data, exp[b]);
                chk("ack_pulse", ack, 0);
            end
            tx_rd = 1'b1;
            @(negedge clk);
            tx_rd = 1'b0;
            chk("gap_low", tx_ready, 0);
            chk("busy_after_rd", busy, (b == n - 1) ? 1'b0 : 1'b1);
            if (b != n - 1 && b != n_rd - 1) begin
                @(negedge clk);
                chk("next_ready", tx_ready, 1);
                chk("next_byte", tx_data, exp[b+1]);
            end
        end
    endtask

    initial begin
        rst = 1'b0; req = '0; word = '0; tx_rd = 1'b0;
        req_b = '0; word_b = '0; tx_rd_b = 1'b0;

        add_vec(3'b001, {32'h0, 32'h0, 32'h1234ABCD}, 0, "1234ABCD\r\n", 3, 1'b0);
        add_vec(3'b011, {32'h0, 32'hFFFFFFFF, 32'h0}, 1, "FFFFFFFF\r\n", 0, 1'b1);
        add_vec(3'b011, {32'h0, 32'hFFFFFFFF, 32'h0}, 0, "00000000\r\n", 1, 1'b1);
        add_vec(3'b011, {32'h0, 32'hFFFFFFFF, 32'h0}, 1, "FFFFFFFF\r\n", 2, 1'b1);
        add_vec(3'b011, {32'h0, 32'hFFFFFFFF, 32'h0}, 0, "00000000\r\n", 0, 1'b0);
        add_vec(3'b100, {32'hCAFE0123, 32'h0, 32'h0}, 2, "CAFE0123\r\n", 1000, 1'b0);
        add_vec(3'b111, {32'h89ABCDEF, 32'h76543210, 32'h01234567}, 0, "01234567\r\n", 1, 1'b0);
        add_vec(3'b110, {32'h89ABCDEF, 32'h76543210, 32'h01234567}, 1, "76543210\r\n", 2, 1'b0);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", tx_ready, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_gid", grant_id, 0);
        rst = 1'b1;

        // tx_rd while idle is ignored
        tx_rd = 1'b1;
        repeat (3) @(negedge clk);
        tx_rd = 1'b0;
        chk("idle_rd_busy", busy, 0);
        chk("idle_rd_ready", tx_ready, 0);
        chk("idle_rd_ack", ack, 0);

        foreach (tbl[i]) begin
            req  = tbl[i].req;
            word = tbl[i].words;
            run_word(tbl[i].ch, tbl[i].exp, tbl[i].dly, tbl[i].keep, tbl[i].exp.len());
        end
        req = '0;
        @(negedge clk);
        chk("gid_hold", grant_id, 1);
        chk("idle_busy", busy, 0);

        // Reset in the middle of a word
        req = 3'b001;
        word = {32'h0, 32'h13579BDF, 32'hDEADBEEF};
        run_word(0, "DEADBEEF\r\n", 1, 1'b1, 3);
        @(negedge clk);
        chk("pre_rst_ready", tx_ready, 1);
        chk("pre_rst_byte3", tx_data, 8'h44);
        req = 3'b010;
        #2 rst = 1'b0;
        #1;
        chk("async_ready", tx_ready, 0);
        chk("async_busy", busy, 0);
        chk("async_ack", ack, 0);
        chk("async_data", tx_data, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        last_m = NCH - 1;
        run_word(1, "13579BDF\r\n", 0, 1'b0, 10);

        // Randomized traffic against the model
        for (int it = 0; it < 40; it++) begin
            req  = 3'($urandom_range(0, 7));
            word = {$urandom, $urandom, $urandom};
            if (req == 3'b000) begin
                tx_rd = 1'b1;
                @(negedge clk);
                tx_rd = 1'b0;
                chk("rnd_idle_busy", busy, 0);
                chk("rnd_idle_ready", tx_ready, 0);
                chk("rnd_idle_ack", ack, 0);
            end else begin
                int ch;
                string exp;
                ch  = pick(req, last_m);
                exp = model_str(word[ch*32 +: 32]);
                run_word(ch, exp, $urandom_range(0, 3), 1'($urandom_range(0, 1)), exp.len());
            end
        end
        req = '0;

        // Two-digit, no line ending instance
        req_b  = 2'b01;
        word_b = 16'h990F;
        @(negedge clk);
        chk("b_ack", ack_b, 2'b01);
        chk("b_ready0", txr_b, 1);
        chk("b_byte0", txd_b, 8'h30);
        req_b   = '0;
        tx_rd_b = 1'b1;
        @(negedge clk);
        tx_rd_b = 1'b0;
        chk("b_gap", txr_b, 0);
        chk("b_busy_mid", busy_b, 1);
        @(negedge clk);
        chk("b_ready1", txr_b, 1);
        chk("b_byte1", txd_b, 8'h46);
        tx_rd_b = 1'b1;
        @(negedge clk);
        tx_rd_b = 1'b0;
        chk("b_done_ready", txr_b, 0);
        chk("b_done_busy", busy_b, 0);
        @(negedge clk);
        chk("b_stay_idle", txr_b, 0);
        chk("b_stay_ack", ack_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
